fm_input_sequencer: RTL and testbench
=====================================

Name: fm_input_sequencer

Overview:
Clocked driver that sits directly upstream of the 2-input fundamental-mode asynchronous state machine (X[1:0] in, Z[1:0] out). It accepts requested input vectors over a valid/ready handshake and applies them to X one bit at a time, so X never changes by two bits at once. After each change it holds X for a settle window, then samples Z through a synchroniser. It returns the sampled Z, a stability flag and the step count over a valid/ready response channel.

Parameters:
SETTLE_CYCLES, 4, clock cycles X is held after each change before the next change or the sample; legal range 3..255.
CNT_W, 8, settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
clk  in  1  single clock; all flops rise-edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request; equals 1 only in IDLE
req_x  in  2  target X vector
x_out  out  2  drives X of the async machine; bit0 = X1, bit1 = X2
z_in  in  2  Z from the async machine; asynchronous to clk
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_z  out  2  synchronised Z sampled at the end of the final settle window
rsp_steps  out  2  single-bit steps applied: 0, 1 or 2
rsp_unstable  out  1  synchronised Z changed between the last two sample edges

Behaviour:
- Reset (async, active-high):
  - state = IDLE, x_out = 00, synchroniser flops = 00, counter = 0.
  - rsp_valid = 0, rsp_z = 00, rsp_steps = 00, rsp_unstable = 0.
  - req_ready = 1 once reset is released.
- z_sync is z_in passed through a 2-flop synchroniser; it is the only path by which z_in reaches logic.
- State IDLE:
  - req_ready = 1.
  - On the edge where req_valid & req_ready, latch target = req_x and compute diff = target ^ x_out.
  - diff = 00: x_out unchanged, steps = 0.
  - diff = 01 or 10: x_out <= target, steps = 1.
  - diff = 11: x_out[0] flips first, steps = 2.
  - In every case load counter = SETTLE_CYCLES-1 and go to SETTLE.
- State SETTLE:
  - x_out is held stable.
  - When counter != 0: decrement by 1 each edge.
  - When counter == 0 and x_out != target: flip x_out[1], reload counter = SETTLE_CYCLES-1, stay in SETTLE.
  - When counter == 0 and x_out == target: capture rsp_z = z_sync, rsp_steps = steps, rsp_unstable = (z_sync != z_sync value at the previous edge), go to RESP.
- State RESP:
  - rsp_valid = 1; rsp_* are held stable.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE.
  - A new request can be accepted on the cycle after that.
- Latency:
  - rsp_valid rises k·SETTLE_CYCLES+1 edges after the handshake edge, where k = max(steps, 1).
  - With the default of 4: 5 edges for 0 or 1 step, 9 edges for 2 steps.
- Fundamental-mode guarantee: outside reset, x_out never changes in more than one bit per edge, and successive changes are at least SETTLE_CYCLES edges apart.
- Bit order: on a two-bit change, bit0 always changes before bit1.
- req_valid while busy: ignored; req_x is not sampled.
- rsp_ready while not in RESP: ignored.
- Reset mid-operation: x_out returns to 00 immediately and the pending response is discarded. A two-bit change on x_out during reset is permitted; the fundamental-mode guarantee does not apply under reset.
- The counter saturates at 0 and never underflows.

Decomposition:
- Package fm_seq_pkg:
  - state typedef {IDLE, SETTLE, RESP};
  - SETTLE_MIN = 3;
  - the 2-bit vector typedef shared by x_out, z_in and rsp_z.
- Sub-module fm_sync2: parameterised-width 2-flop synchroniser with async active-high reset to 0, instantiated for z_in.
- All other logic lives in fm_input_sequencer.

Test Plan:
1. Assert rst mid-window, then hold rst high -> x_out = 00, rsp_valid = 0, rsp_z = 00 immediately; req_ready = 1 after release; the discarded request produces no response.
2. From x_out = 00, request req_x = 01 with z_in held 10 -> x_out = 01 on the handshake edge; rsp_valid 5 edges later; rsp_z = 10, rsp_steps = 1, rsp_unstable = 0.
3. From 00, request req_x = 11 -> x_out = 01 for 4 cycles, then 11; x_out never equals 10; rsp_valid 9 edges after the handshake; rsp_steps = 2.
4. Request req_x equal to the current x_out (01) -> x_out unchanged; rsp_steps = 0; rsp_valid 5 edges after the handshake.
5. Hold rsp_ready = 0 for 6 cycles while req_valid = 1 with req_x = 10 -> req_ready = 0, rsp_* stable, no x_out change; raise rsp_ready -> IDLE, then the new request is accepted.
6. Toggle z_in between 00 and 11 every cycle during the settle window -> rsp_unstable = 1. A z_in constant for the whole window -> rsp_unstable = 0.

Source files
------------

// File: rtl/fm_seq_pkg.sv
// Shared types and constants for the fundamental-mode input sequencer.
// The 2-bit vector type is used for X, Z and the captured response Z.
package fm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  localparam int SETTLE_MIN = 3;

  typedef logic [1:0] vec2_t;

  // Number of single-bit changes needed to reach a target: 0, 1 or 2.
  function automatic logic [1:0] step_count(input vec2_t diff);
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // First X vector to apply; a two-bit change starts with bit0 alone.
  function automatic vec2_t first_step(input vec2_t cur, input vec2_t tgt);
    vec2_t diff;
    diff = cur ^ tgt;
    if (diff == 2'b11) begin
      return cur ^ 2'b01;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/fm_sync2.sv
// Two-flop synchroniser for signals asynchronous to clk; resets to all zeros.
module fm_sync2 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: clocked state uses non-blocking assignments so both flops sample
  // their inputs from the same edge and the chain never collapses to one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fm_input_sequencer.sv
// Drives X of a fundamental-mode async machine one bit at a time, waits a
// settle window after each change, then reports the synchronised Z.
module fm_input_sequencer
  import fm_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_x,
  output logic [1:0] x_out,
  input  logic [1:0] z_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_z,
  output logic [1:0] rsp_steps,
  output logic       rsp_unstable
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  vec2_t            target;
  logic [1:0]       steps;
  logic [CNT_W-1:0] cnt;
  vec2_t            z_sync;
  vec2_t            z_prev;
  vec2_t            diff;

  // z_in is only ever observed through this synchroniser.
  fm_sync2 #(.W(2)) u_z_sync (
    .clk (clk),
    .rst (rst),
    .d   (z_in),
    .q   (z_sync)
  );

  assign req_ready = (state == IDLE);
  assign diff      = req_x ^ x_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      x_out        <= '0;
      target       <= '0;
      steps        <= '0;
      cnt          <= '0;
      z_prev       <= '0;
      rsp_valid    <= 1'b0;
      rsp_z        <= '0;
      rsp_steps    <= '0;
      rsp_unstable <= 1'b0;
    end else begin
      // Previous-edge copy of z_sync, used to flag a Z still moving at sample time.
      z_prev <= z_sync;

      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            target <= req_x;
            steps  <= step_count(diff);
            x_out  <= first_step(x_out, req_x);
            cnt    <= RELOAD;
            state  <= SETTLE;
          end
        end

        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (x_out != target) begin
            // Only bit1 can still differ here; bit0 was applied first.
            x_out[1] <= ~x_out[1];
            cnt      <= RELOAD;
          end else begin
            rsp_z        <= z_sync;
            rsp_steps    <= steps;
            rsp_unstable <= (z_sync != z_prev);
            state        <= RESP;
          end
        end

        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_input_sequencer.sv
// Directed bench for fm_input_sequencer with a response scoreboard and an
// always-on monitor of the one-bit-at-a-time X guarantee.
module tb_fm_input_sequencer;
  import fm_seq_pkg::*;

  localparam int SETTLE = 4;

  typedef struct {
    logic [1:0] z;
    logic [1:0] steps;
    logic       unst;
    int         lat;
    bit         chk_z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_x = 2'b00;
  logic [1:0] x_out;
  logic [1:0] z_in = 2'b00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [1:0] rsp_z;
  logic [1:0] rsp_steps;
  logic       rsp_unstable;

  logic [1:0] z_const = 2'b00;
  bit         z_toggle = 1'b0;
  logic [1:0] trace [0:63];
  exp_t       sb [$];

  int vectors = 0;
  int miscompares = 0;

  fm_input_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .x_out        (x_out),
    .z_in         (z_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_z        (rsp_z),
    .rsp_steps    (rsp_steps),
    .rsp_unstable (rsp_unstable)
  );

  always #5 clk = ~clk;

  // Z source: constant, or toggling 00/11 every cycle, changed on the falling edge.
  always @(negedge clk) begin
    if (z_toggle) z_in = ~z_in;
    else          z_in = z_const;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // X may change in only one bit at a time and no sooner than SETTLE edges apart.
  int    since = 100;
  vec2_t prev_x = 2'b00;
  always @(negedge clk) begin
    if (rst) begin
      prev_x = x_out;
      since  = 100;
    end else begin
      since++;
      if (x_out !== prev_x) begin
        chk("x_one_bit_change", 32'($countones(x_out ^ prev_x)), 32'd1);
        chk("x_change_spacing", {31'd0, since >= SETTLE}, 32'd1);
        since  = 0;
        prev_x = x_out;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected response, then hold the request until the handshake edge.
  task automatic start_req(input logic [1:0] x, input logic [1:0] ez, input logic [1:0] esteps,
                           input logic eunst, input int elat, input bit chkz);
    exp_t e;
    int   n;
    e.z = ez; e.steps = esteps; e.unst = eunst; e.lat = elat; e.chk_z = chkz;
    sb.push_back(e);
    req_valid = 1'b1;
    req_x     = x;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_ready_before_handshake", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Count edges from the handshake edge to rsp_valid, recording x_out per edge.
  task automatic wait_rsp(output int lat);
    exp_t e;
    lat = 0;
    trace[0] = x_out;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
      trace[lat] = x_out;
    end
    chk("rsp_valid_within_bound", {31'd0, rsp_valid}, 32'd1);
    chk("scoreboard_nonempty", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.chk_z) chk("rsp_z", {30'd0, rsp_z}, {30'd0, e.z});
      chk("rsp_steps", {30'd0, rsp_steps}, {30'd0, e.steps});
      chk("rsp_unstable", {31'd0, rsp_unstable}, {31'd0, e.unst});
      chk("rsp_latency", lat, e.lat);
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;

    // Power-on reset.
    #1 rst = 1'b1;
    #2;
    chk("por_x_out", {30'd0, x_out}, 32'd0);
    chk("por_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("por_rsp_z", {30'd0, rsp_z}, 32'd0);
    chk("por_rsp_steps", {30'd0, rsp_steps}, 32'd0);
    chk("por_rsp_unstable", {31'd0, rsp_unstable}, 32'd0);
    step();
    step();
    rst = 1'b0;
    z_const = 2'b10;
    step();
    chk("req_ready_after_por", {31'd0, req_ready}, 32'd1);

    // Test 1: reset in the middle of a two-step request discards it.
    start_req(2'b11, 2'b10, 2'd2, 1'b0, 9, 1'b1);
    repeat (4) step();
    chk("pre_rst_x_out", {30'd0, x_out}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_x_out", {30'd0, x_out}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_z", {30'd0, rsp_z}, 32'd0);
    repeat (3) step();
    rst = 1'b0;
    sb.delete();
    step();
    chk("req_ready_after_rst", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("no_rsp_after_rst", {31'd0, seen}, 32'd0);
    chk("x_out_idle_after_rst", {30'd0, x_out}, 32'd0);

    // Test 3: 00 -> 11 goes through 01, never 10.
    start_req(2'b11, 2'b10, 2'd2, 1'b0, 9, 1'b1);
    wait_rsp(lat);
    chk("t3_first_step_x", {30'd0, trace[0]}, 32'd1);
    chk("t3_hold_x", {30'd0, trace[3]}, 32'd1);
    chk("t3_second_step_x", {30'd0, trace[4]}, 32'd3);
    seen = 1'b0;
    for (int i = 0; i <= lat && i < 64; i++) if (trace[i] === 2'b10) seen = 1'b1;
    chk("t3_never_10", {31'd0, seen}, 32'd0);
    accept_rsp();

    // Back to 00: bit0 changes first, so 11 -> 10 -> 00.
    start_req(2'b00, 2'b10, 2'd2, 1'b0, 9, 1'b1);
    wait_rsp(lat);
    chk("ret_first_step_x", {30'd0, trace[0]}, 32'd2);
    chk("ret_final_x", {30'd0, x_out}, 32'd0);
    accept_rsp();

    // Test 2: single step 00 -> 01 with Z held at 10.
    start_req(2'b01, 2'b10, 2'd1, 1'b0, 5, 1'b1);
    wait_rsp(lat);
    chk("t2_x_on_handshake", {30'd0, trace[0]}, 32'd1);
    accept_rsp();

    // Test 4: request equal to current X.
    start_req(2'b01, 2'b10, 2'd0, 1'b0, 5, 1'b1);
    wait_rsp(lat);
    chk("t4_x_unchanged", {30'd0, trace[0]}, 32'd1);
    chk("t4_x_unchanged_end", {30'd0, x_out}, 32'd1);

    // Test 5: response back-pressure while a new request waits.
    req_valid = 1'b1;
    req_x     = 2'b10;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_req_ready_low", {31'd0, req_ready}, 32'd0);
      chk("t5_rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
      chk("t5_rsp_z_held", {30'd0, rsp_z}, 32'd2);
      chk("t5_rsp_steps_held", {30'd0, rsp_steps}, 32'd0);
      chk("t5_x_held", {30'd0, x_out}, 32'd1);
    end
    accept_rsp();
    start_req(2'b10, 2'b10, 2'd2, 1'b0, 9, 1'b1);
    wait_rsp(lat);
    chk("t5_bit0_first", {30'd0, trace[0]}, 32'd0);
    chk("t5_final_x", {30'd0, x_out}, 32'd2);
    accept_rsp();

    // Test 6: Z toggling through the window flags unstable; constant Z does not.
    z_const = 2'b00;
    repeat (2) step();
    z_toggle = 1'b1;
    start_req(2'b11, 2'b00, 2'd1, 1'b1, 5, 1'b0);
    wait_rsp(lat);
    z_toggle = 1'b0;
    accept_rsp();
    z_const = 2'b01;
    repeat (4) step();
    start_req(2'b01, 2'b01, 2'd1, 1'b0, 5, 1'b1);
    wait_rsp(lat);
    accept_rsp();

    chk("scoreboard_drained", sb.size(), 32'd0);
    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
